mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, memory word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter READ_LAT, default 1, cycles from mem_read_enable high to valid mem_data_out (range 1..4).
REQ-004 Parameter STARVE_MAX, default 4, consecutive data-port wins tolerated while fetch pending.
REQ-005 One clock, clk; reset rst, asynchronous, active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  async active-high reset.
REQ-008 if_req  in  1  fetch read request, held until if_gnt.
REQ-009 if_addr  in  ADDR_W  fetch address.
REQ-010 if_gnt  out  1  one-cycle fetch accept pulse.
REQ-011 if_rvalid  out  1  one-cycle fetch read-data-valid pulse.
REQ-012 if_rdata  out  DATA_W  fetch read data.
REQ-013 d_req  in  1  data-port request, held until d_gnt.
REQ-014 d_we  in  1  1 = write, 0 = read.
REQ-015 d_addr  in  ADDR_W  data-port address.
REQ-016 d_wdata  in  DATA_W  write data.
REQ-017 d_gnt  out  1  one-cycle data-port accept pulse.
REQ-018 d_rvalid  out  1  one-cycle data-port read-data-valid pulse.
REQ-019 d_rdata  out  DATA_W  data-port read data.
REQ-020 mem_addr  out  ADDR_W  to memory_v2 mem_addr.
REQ-021 mem_data_in  out  DATA_W  to memory_v2 data_in.
REQ-022 mem_write_enable  out  1  to memory_v2 write_enable.
REQ-023 mem_read_enable  out  1  to memory_v2 read_enable.
REQ-024 mem_data_out  in  DATA_W  from memory_v2 data_out.
REQ-025 busy  out  1  high whenever state != IDLE.

Function
REQ-026 FSM states IDLE, ISSUE, WAIT; one transaction outstanding at most.
REQ-027 gnt: combinational, only in IDLE, at most one of if_gnt/d_gnt high per cycle.
REQ-028 Selection in IDLE: d_req alone -> data; if_req alone -> fetch; both -> data, except starve_cnt == STARVE_MAX -> fetch.
REQ-029 starve_cnt: +1 on d_gnt while if_req high (saturating at STARVE_MAX); cleared on if_gnt or whenever if_req low.
REQ-030 On grant cycle T: latch port id, address, we (fetch forces we=0), wdata; next state ISSUE.
REQ-031 ISSUE (T+1): registered mem_addr/mem_data_in from latch; exactly one of mem_write_enable/mem_read_enable high for this single cycle.
REQ-032 Write: ISSUE -> IDLE; no rvalid; next grant possible at T+2.
REQ-033 Read: ISSUE -> WAIT; WAIT lasts READ_LAT cycles; on its last cycle mem_data_out is sampled into the granted port's rdata register, state -> IDLE.
REQ-034 Granted port's rvalid high for one cycle at T+2+READ_LAT (=T+3 default), concurrent with IDLE; a new grant may occur in that cycle.
REQ-035 Enables low in IDLE and WAIT; mem_write_enable and mem_read_enable never both high.
REQ-036 rdata registers hold last captured value until next capture for that port; other port's rdata unchanged.
REQ-037 Requests arriving in ISSUE/WAIT get no gnt; they wait. A request dropped before gnt causes no memory access.
REQ-038 Addresses and data pass unmodified; no width conversion.

Reset
REQ-039 rst high, any state, any cycle: state IDLE, starve_cnt 0, all gnt/rvalid/enables 0, mem_addr 0, mem_data_in 0, rdata 0, busy 0; in-flight read discarded, no rvalid after release.
REQ-040 First grant possible in the first clk edge cycle after rst deasserts.

Verification
REQ-041 Preload mem[5]=0xDEADBEEF; if_req, if_addr=5 at T -> if_gnt T, mem_read_enable T+1 addr 5, if_rvalid T+3 with if_rdata=0xDEADBEEF, d_rvalid 0.
REQ-042 d_req, d_we=1, d_addr=9, d_wdata=0x12345678 at T -> mem_write_enable T+1 only, no rvalid; then data read addr 9 -> d_rdata=0x12345678.
REQ-043 if_req and d_req held continuously, data reads -> grants D,D,D,D,F,D,D,D,D,F...; never two gnts same cycle.
REQ-044 Read granted at T, rst pulsed at T+2 -> no rvalid at T+3; all outputs 0; next request serviced normally.
REQ-045 Write granted T, if_req raised T+1 -> if_gnt not before T+2; busy high T+1, low T+2.
REQ-046 READ_LAT=3 build: read granted T -> rvalid at T+5 with correct data.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch + data) arbiter in front of a single-ported synchronous memory.
// One transaction in flight; data port wins ties unless fetch has been starved STARVE_MAX times.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int unsigned LatW = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q;
  logic [CntW-1:0] starve_q;
  logic [LatW-1:0] lat_q;
  logic            port_q;  // 1 = data port owns the transaction in flight
  logic            pick_d;

  // Data wins ties until fetch has lost STARVE_MAX times in a row.
  assign pick_d = d_req && (!if_req || (starve_q != CntW'(STARVE_MAX)));
  assign d_gnt  = (state_q == StIdle) && pick_d;
  assign if_gnt = (state_q == StIdle) && if_req && !pick_d;
  assign busy   = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      starve_q         <= '0;
      lat_q            <= '0;
      port_q           <= 1'b0;
      mem_addr         <= '0;
      mem_data_in      <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      if_rvalid        <= 1'b0;
      d_rvalid         <= 1'b0;
      if_rdata         <= '0;
      d_rdata          <= '0;
    end else begin
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      if_rvalid        <= 1'b0;
      d_rvalid         <= 1'b0;

      if (!if_req || if_gnt) begin
        starve_q <= '0;
      end else if (d_gnt && (starve_q != CntW'(STARVE_MAX))) begin
        starve_q <= starve_q + CntW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (d_gnt) begin
            port_q           <= 1'b1;
            mem_addr         <= d_addr;
            mem_data_in      <= d_wdata;
            mem_write_enable <= d_we;
            mem_read_enable  <= !d_we;
            state_q          <= StIssue;
          end else if (if_gnt) begin
            port_q           <= 1'b0;
            mem_addr         <= if_addr;
            mem_read_enable  <= 1'b1;
            state_q          <= StIssue;
          end
        end
        StIssue: begin
          // Write enable is still high here exactly when this is a write.
          if (mem_write_enable) begin
            state_q <= StIdle;
          end else begin
            lat_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (lat_q == LatW'(READ_LAT - 1)) begin
            if (port_q) begin
              d_rdata  <= mem_data_out;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_data_out;
              if_rvalid <= 1'b1;
            end
            state_q <= StIdle;
          end else begin
            lat_q <= lat_q + LatW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default build plus a READ_LAT=3 build, each with a
// behavioural synchronous memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;

  // Default build (READ_LAT = 1)
  logic        if_req, if_gnt, if_rvalid;
  logic [9:0]  if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data_in, mem_data_out;
  logic        mem_write_enable, mem_read_enable, busy;

  // READ_LAT = 3 build
  logic        if3_req, if3_gnt, if3_rvalid;
  logic [9:0]  if3_addr;
  logic [31:0] if3_rdata;
  logic        d3_req, d3_we, d3_gnt, d3_rvalid;
  logic [9:0]  d3_addr;
  logic [31:0] d3_wdata, d3_rdata;
  logic [9:0]  mem3_addr;
  logic [31:0] mem3_data_in, mem3_data_out;
  logic        mem3_we, mem3_re, busy3;

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] rd1;
  logic [31:0] rd3 [0:2];

  always #5 clk = ~clk;

  mem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_data_out(mem_data_out), .busy(busy)
  );

  mem_arbiter #(.READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if3_req), .if_addr(if3_addr), .if_gnt(if3_gnt), .if_rvalid(if3_rvalid),
    .if_rdata(if3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata), .d_gnt(d3_gnt),
    .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
    .mem_addr(mem3_addr), .mem_data_in(mem3_data_in), .mem_write_enable(mem3_we),
    .mem_read_enable(mem3_re), .mem_data_out(mem3_data_out), .busy(busy3)
  );

  // Memory models: preload while reset is held, read data appears READ_LAT cycles later.
  always @(posedge clk) begin
    if (rst) mem1[5] <= 32'hDEADBEEF;
    else if (mem_write_enable) mem1[mem_addr] <= mem_data_in;
    rd1 <= mem1[mem_addr];
  end
  assign mem_data_out = rd1;

  always @(posedge clk) begin
    if (rst) mem3[7] <= 32'hCAFEF00D;
    else if (mem3_we) mem3[mem3_addr] <= mem3_data_in;
    rd3[0] <= mem3[mem3_addr];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign mem3_data_out = rd3[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output bit got);
    got = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst = 1'b1;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    if3_req = 0; if3_addr = '0; d3_req = 0; d3_we = 0; d3_addr = '0; d3_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {if_gnt, d_gnt}, 0);
    chk("rst_en", {mem_write_enable, mem_read_enable}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_data_in, 0);
    chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);

    // Fetch read of preloaded word, granted in the first cycle after reset.
    tick(); rst = 0; if_req = 1; if_addr = 10'd5;
    @(negedge clk);
    chk("f_gnt", if_gnt, 1); chk("f_dgnt", d_gnt, 0); chk("f_busy0", busy, 0);
    tick(); if_req = 0;
    @(negedge clk);
    chk("f_re", mem_read_enable, 1); chk("f_we", mem_write_enable, 0);
    chk("f_addr", mem_addr, 5); chk("f_busy1", busy, 1); chk("f_nogntT1", if_gnt, 0);
    tick();
    @(negedge clk);
    chk("f_wait_busy", busy, 1); chk("f_wait_re", mem_read_enable, 0);
    chk("f_wait_rv", if_rvalid, 0);
    tick();
    @(negedge clk);
    chk("f_rvalid", if_rvalid, 1); chk("f_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_drv", d_rvalid, 0); chk("f_busy_end", busy, 0);

    // Data write, fetch raised one cycle later must wait for IDLE.
    tick(); d_req = 1; d_we = 1; d_addr = 10'd9; d_wdata = 32'h12345678;
    @(negedge clk);
    chk("w_gnt", d_gnt, 1); chk("w_ifgnt", if_gnt, 0); chk("f_rv_pulse", if_rvalid, 0);
    tick(); d_req = 0; if_req = 1; if_addr = 10'd5;
    @(negedge clk);
    chk("w_we", mem_write_enable, 1); chk("w_re", mem_read_enable, 0);
    chk("w_addr", mem_addr, 9); chk("w_data", mem_data_in, 32'h12345678);
    chk("w_busy1", busy, 1); chk("w_ifgnt_T1", if_gnt, 0);
    tick();
    @(negedge clk);
    chk("w_busy2", busy, 0); chk("w_ifgnt_T2", if_gnt, 1);
    chk("w_we_off", mem_write_enable, 0); chk("w_norv", {if_rvalid, d_rvalid}, 0);
    tick(); if_req = 0;
    tick();
    tick(); d_req = 1; d_we = 0; d_addr = 10'd9;
    @(negedge clk);
    chk("f2_rvalid", if_rvalid, 1); chk("r_gnt_with_rv", d_gnt, 1);
    tick(); d_req = 0;
    tick();
    tick();
    @(negedge clk);
    chk("r_rvalid", d_rvalid, 1); chk("r_rdata", d_rdata, 32'h12345678);
    chk("r_if_hold", if_rdata, 32'hDEADBEEF); chk("r_if_rv", if_rvalid, 0);

    // Both ports held: D,D,D,D,F repeating.
    tick(); if_req = 1; if_addr = 10'd5; d_req = 1; d_we = 0; d_addr = 10'd9;
    for (int i = 0; i < 10; i++) begin
      wait_gnt(got);
      chk("starve_timeout", got, 1);
      chk("starve_two_gnt", if_gnt & d_gnt, 0);
      chk($sformatf("starve_order_%0d", i), if_gnt, (i % 5) == 4);
    end
    tick(); if_req = 0; d_req = 0;
    repeat (4) tick();

    // Reset in the middle of a read: response discarded.
    d_req = 1; d_we = 0; d_addr = 10'd9;
    @(negedge clk);
    chk("x_gnt", d_gnt, 1);
    tick(); d_req = 0;
    tick(); rst = 1;
    @(negedge clk);
    chk("x_busy", busy, 0); chk("x_en", {mem_write_enable, mem_read_enable}, 0);
    chk("x_addr", mem_addr, 0); chk("x_rdata", {if_rdata, d_rdata}, 0);
    tick(); rst = 0;
    @(negedge clk);
    chk("x_norv", {if_rvalid, d_rvalid}, 0); chk("x_busy_after", busy, 0);
    tick();
    @(negedge clk);
    chk("x_norv2", {if_rvalid, d_rvalid}, 0);
    tick(); if_req = 1; if_addr = 10'd5;
    @(negedge clk);
    chk("x_next_gnt", if_gnt, 1);
    tick(); if_req = 0;
    tick();
    tick();
    @(negedge clk);
    chk("x_next_rv", if_rvalid, 1); chk("x_next_rdata", if_rdata, 32'hDEADBEEF);

    // READ_LAT = 3 build: rvalid five cycles after grant.
    tick(); d3_req = 1; d3_we = 0; d3_addr = 10'd7;
    @(negedge clk);
    chk("l3_gnt", d3_gnt, 1); chk("l3_ifgnt", if3_gnt, 0);
    tick(); d3_req = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("l3_rvalid_T%0d", k), d3_rvalid, k == 5);
      if (k == 5) chk("l3_rdata", d3_rdata, 32'hCAFEF00D);
      if (k == 5) chk("l3_busy", busy3, 0);
      tick();
    end
    chk("l3_if_idle", {if3_rvalid, if3_rdata}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
